// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and helpers for the bit-serial adder.
//   - state_t   : control FSM states (IDLE, RUN, DONE)
//   - cnt_width : bit counter width, max(1, clog2(width))
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A one-bit counter is still needed when width is 1 or 2.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// fa_bit
//   Purely combinational one-bit full adder.
//   Ports:
//     a, b, ci : addend bits and carry-in
//     s        : sum bit, a ^ b ^ ci
//     co       : carry-out, majority(a, b, ci)
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial, LSB-first adder: S = A + B + Cin computed over WIDTH cycles
//   using a single full-add cell and a carry flip-flop.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//     A, B, Cin           : operands, captured on the accept edge
//     out_valid/out_ready : result handshake (out_valid high only in DONE)
//     S, Cout             : sum (mod 2^WIDTH) and carry-out; held until the
//                           next result completes
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_s;
    logic [WIDTH-1:0] sh_s_next;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    fa_bit u_fa (
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the LSB-first
    // stream is aligned. Written as a widened shift so WIDTH=1 needs no
    // special case.
    assign sh_s_next = WIDTH'({fa_s, sh_s} >> 1);
    assign last_bit  = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // S/Cout are separate from the shift register so they stay stable
    // after the handshake while the next operation is shifting.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            carry <= 1'b0;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            S     <= '0;
            Cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_a  <= A;
                        sh_b  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sh_s  <= sh_s_next;
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        S    <= sh_s_next;
                        Cout <= fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
